// File: rtl/joystick_pkg.sv
// joystick_pkg: shared states and constants for the joystick ADC sampler
package joystick_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, BACK} spi_state_t;
  localparam logic [9:0] JOY_CENTER = 10'h200;
  localparam int ADC_BITS = 10;
  localparam int SPI_FRAME = 16;
endpackage

// File: rtl/spi_mstr16.sv
// spi_mstr16: single 16-bit mode-0 SPI transaction master with trailing SS_n hold
module spi_mstr16
  import joystick_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic        miso,
  output logic        sclk,
  output logic        ss_n,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx
);
  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(SCLK_DIV / 2);
  localparam logic [DW-1:0] BACK_LAST = DW'(SCLK_DIV / 2 - 1);
  spi_state_t state, state_d;
  logic [DW-1:0] div_cnt, div_d, div_inc;
  logic [4:0] bit_cnt, bit_d, bit_nxt;
  logic sclk_d, ss_d, mosi_d, busy_d;
  logic [15:0] rx_d;
  assign div_inc = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign bit_nxt = bit_cnt + 5'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk <= 1'b0;
      ss_n <= 1'b1;
      mosi <= 1'b0;
      busy <= 1'b0;
      rx <= '0;
    end else begin
      state <= state_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      sclk <= sclk_d;
      ss_n <= ss_d;
      mosi <= mosi_d;
      busy <= busy_d;
      rx <= rx_d;
    end
  end
  always_comb begin
    state_d = state;
    div_d = div_cnt;
    bit_d = bit_cnt;
    sclk_d = sclk;
    ss_d = ss_n;
    mosi_d = mosi;
    busy_d = busy;
    rx_d = rx;
    done = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_d = SHIFT;
        ss_d = 1'b0;
        mosi_d = cmd[15];
        busy_d = 1'b1;
        div_d = '0;
        bit_d = '0;
      end
      SHIFT: begin
        div_d = div_inc;
        if (div_inc == HALF) begin
          sclk_d = 1'b1;
          rx_d = {rx[14:0], miso};
        end
        if (div_cnt == DIV_LAST) begin
          sclk_d = 1'b0;
          bit_d = bit_nxt;
          mosi_d = (bit_nxt == 5'(SPI_FRAME)) ? 1'b0 : cmd[~bit_nxt[3:0]];
          state_d = (bit_nxt == 5'(SPI_FRAME)) ? BACK : SHIFT;
        end
      end
      BACK: begin
        div_d = (div_cnt == BACK_LAST) ? '0 : div_cnt + 1'b1;
        if (div_cnt == BACK_LAST) begin
          state_d = IDLE;
          ss_d = 1'b1;
          busy_d = 1'b0;
          done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/joystick_spi_sampler.sv
// joystick_spi_sampler: periodic ADC read over SPI, presents the 10-bit joystick position
module joystick_spi_sampler
  import joystick_pkg::*;
#(
  parameter int          SCLK_DIV      = 32,
  parameter int          SAMPLE_PERIOD = 4096,
  parameter logic [15:0] CMD_WORD      = 16'h6000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                MISO,
  output logic                SCLK,
  output logic                SS_n,
  output logic                MOSI,
  output logic [ADC_BITS-1:0] joystick_data,
  output logic                data_vld,
  output logic                busy
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  logic [TW-1:0] timer;
  logic tick, done;
  logic [15:0] rx;
  assign tick = (timer == TW'(SAMPLE_PERIOD - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      joystick_data <= JOY_CENTER;
      data_vld <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      data_vld <= done;
      if (done) joystick_data <= rx[ADC_BITS-1:0];
    end
  end
  spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk  (clk),
    .rst  (rst),
    .start(tick & en),
    .cmd  (CMD_WORD),
    .miso (MISO),
    .sclk (SCLK),
    .ss_n (SS_n),
    .mosi (MOSI),
    .busy (busy),
    .done (done),
    .rx   (rx)
  );
endmodule

// File: tb/tb_joystick_spi_sampler.sv
// tb_joystick_spi_sampler: directed checks of frame timing, data capture, en gating and reset abort
module tb_joystick_spi_sampler;
  localparam int DIV = 4, PER = 128;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic MISO, SCLK, SS_n, MOSI, data_vld, busy;
  logic [9:0] joystick_data;
  logic [15:0] adc_word = 16'h03A5;
  int total = 0, bad = 0, cyc = 0, nf = 0;
  int at, f0, rc, v, n, fl;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // ADC model: MSB presented at SS_n fall, next bit after each SCLK fall
  always @(negedge SCLK or posedge SS_n) nf <= SS_n ? 0 : nf + 1;
  assign MISO = adc_word[15 - (nf > 15 ? 15 : nf)];
  joystick_spi_sampler #(.SCLK_DIV(DIV), .SAMPLE_PERIOD(PER), .CMD_WORD(16'h6000)) dut (
    .clk(clk), .rst(rst), .en(en), .MISO(MISO), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .joystick_data(joystick_data), .data_vld(data_vld), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_fall(input int lim, output int fall_at, output int vlds);
    fall_at = -1;
    vlds = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (data_vld) vlds++;
      if (!SS_n) begin
        fall_at = cyc;
        break;
      end
    end
  endtask
  task automatic frame_chk(input string t, input logic [9:0] exp, input int drop);
    int rises = 0, first = -1, low = 1, vlds = 0;
    logic [15:0] mw = '0;
    logic [9:0] d = '0;
    logic va = 1'b0, prev;
    prev = SCLK;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == drop) en = 1'b0;
      if (SCLK && !prev) begin
        rises++;
        mw = {mw[14:0], MOSI};
        if (rises == 1) first = i;
      end
      prev = SCLK;
      if (data_vld) vlds++;
      if (SS_n) begin
        va = data_vld;
        d = joystick_data;
        break;
      end
      low++;
    end
    @(negedge clk);
    if (data_vld) vlds++;
    chk({t, "_rises"}, rises, 16);
    chk({t, "_first_rise"}, first, 2);
    chk({t, "_ss_low"}, low, 66);
    chk({t, "_mosi"}, mw, 16'h6000);
    chk({t, "_vld_at_ss_rise"}, va, 1);
    chk({t, "_vld_count"}, vlds, 1);
    chk({t, "_data"}, d, exp);
    chk({t, "_data_held"}, joystick_data, exp);
    chk({t, "_busy_idle"}, busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", joystick_data, 10'h200);
    chk("rst_vld", data_vld, 0);
    rst = 1'b0;
    repeat (PER - 1) @(posedge clk);
    @(negedge clk);
    chk("pre_tick_ss_n", SS_n, 1);
    @(posedge clk);
    @(negedge clk);
    chk("tick_ss_n", SS_n, 0);
    chk("tick_busy", busy, 1);
    f0 = cyc;
    frame_chk("f1", 10'h3A5, -1);
    adc_word = 16'hFFFF;
    wait_fall(200, at, v);
    chk("f2_period", at - f0, PER);
    f0 = at;
    frame_chk("f2", 10'h3FF, -1);
    adc_word = 16'h0000;
    wait_fall(200, at, v);
    chk("f3_period", at - f0, PER);
    f0 = at;
    frame_chk("f3", 10'h000, -1);
    en = 1'b0;
    v = 0;
    fl = 0;
    repeat (400) begin
      @(negedge clk);
      if (!SS_n) fl++;
      if (data_vld) v++;
    end
    chk("en_off_falls", fl, 0);
    chk("en_off_vld", v, 0);
    chk("en_off_data", joystick_data, 10'h000);
    en = 1'b1;
    adc_word = 16'h03A5;
    n = f0 + ((cyc - f0) / PER + 1) * PER;
    wait_fall(200, at, v);
    chk("en_resume_fall", at, n);
    frame_chk("f4", 10'h3A5, -1);
    wait_fall(200, at, v);
    n = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin
      @(posedge SCLK or negedge clk);
      if (SCLK && clk) n++;
    end
    @(negedge clk);
    chk("abort_rise_count", n, 8);
    rst = 1'b1;
    @(negedge clk);
    rc = cyc;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_data", joystick_data, 10'h200);
    chk("abort_vld", data_vld, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    adc_word = 16'hFC55;
    wait_fall(300, at, v);
    chk("abort_no_vld", v, 0);
    chk("abort_timer_restart", at - rc, PER);
    frame_chk("f5_en_drop", 10'h055, 20);
    wait_fall(300, at, v);
    chk("en_drop_no_frame", at, -1);
    chk("en_drop_no_vld", v, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
